// File: rtl/axi4_burst_mem_slave.sv
// AXI4 memory slave: FIXED/INCR/WRAP bursts, narrow beats, byte strobes.
// Independent write and read FSMs over a word-organised RAM.
module axi4_burst_mem_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int IW    = ADDR_WIDTH - LB;
  localparam int MW    = $clog2(MEMORY_DEPTH);
  localparam logic [IW:0] DEPTH    = (IW+1)'(MEMORY_DEPTH);
  localparam logic [2:0]  MAX_SIZE = 3'(LB);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  function automatic logic bad_cmd(input logic [7:0] len,
                                   input logic [2:0] size,
                                   input logic [1:0] burst);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) ||
              (len == 8'd7) || (len == 8'd15);
    return (size > MAX_SIZE) || (burst == 2'b11) ||
           (burst == 2'b10 && !wrap_ok);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] step(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [7:0]            len,
    input logic [2:0]            size,
    input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] incr, mask;
    incr = ADDR_WIDTH'(1) << size;
    mask = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * incr - ADDR_WIDTH'(1);
    unique case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | ((a + incr) & mask);
      default: return a + incr;
    endcase
  endfunction

  // ---------------- write channel ----------------
  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]            wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0]            wsize_q, wsize_d;
  logic [1:0]            wburst_q, wburst_d;
  logic                  wcmd_err_q, wcmd_err_d, werr_q, werr_d;
  logic                  w_hs, w_inr, w_we;
  logic [MW-1:0]         w_idx;

  assign w_inr = {1'b0, waddr_q[ADDR_WIDTH-1:LB]} < DEPTH;
  assign w_idx = waddr_q[LB +: MW];
  assign w_hs  = WVALID && wready_q;
  assign w_we  = w_hs && !wcmd_err_q && w_inr;

  always_comb begin
    w_state_d  = w_state_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    wbeat_d    = wbeat_q;
    wcmd_err_d = wcmd_err_q;
    werr_d     = werr_q;
    unique case (w_state_q)
      W_IDLE: if (AWVALID && awready_q) begin
        waddr_d    = AWADDR;
        wlen_d     = AWLEN;
        wsize_d    = AWSIZE;
        wburst_d   = AWBURST;
        wbeat_d    = 8'd0;
        wcmd_err_d = bad_cmd(AWLEN, AWSIZE, AWBURST);
        werr_d     = wcmd_err_d;
        w_state_d  = W_DATA;
      end
      W_DATA: if (w_hs) begin
        // burst length is set by the beat count; a bad WLAST only flags
        werr_d  = werr_q | !w_inr | (WLAST != (wbeat_q == wlen_q));
        waddr_d = step(waddr_q, wlen_q, wsize_q, wburst_q);
        wbeat_d = wbeat_q + 8'd1;
        if (wbeat_q == wlen_q) w_state_d = W_RESP;
      end
      W_RESP: if (BREADY && bvalid_q) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = bvalid_d ? {werr_d, 1'b0} : 2'b00;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wsize_q    <= '0;
      wburst_q   <= '0;
      wbeat_q    <= '0;
      wcmd_err_q <= 1'b0;
      werr_q     <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wsize_q    <= wsize_d;
      wburst_q   <= wburst_d;
      wbeat_q    <= wbeat_d;
      wcmd_err_q <= wcmd_err_d;
      werr_q     <= werr_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, r_addr;
  logic [7:0]            rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic                  rcmd_err_q, rcmd_err_d, r_load, r_inr;
  logic [MW-1:0]         r_idx;

  // raddr_q always holds the address of the next beat to load
  assign r_addr = (r_state_q == R_IDLE) ? ARADDR : raddr_q;
  assign r_inr  = {1'b0, r_addr[ADDR_WIDTH-1:LB]} < DEPTH;
  assign r_idx  = r_addr[LB +: MW];

  always_comb begin
    r_state_d  = r_state_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rsize_d    = rsize_q;
    rburst_d   = rburst_q;
    rbeat_d    = rbeat_q;
    rcmd_err_d = rcmd_err_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    r_load     = 1'b0;
    unique case (r_state_q)
      R_IDLE: if (ARVALID && arready_q) begin
        r_load     = 1'b1;
        rlen_d     = ARLEN;
        rsize_d    = ARSIZE;
        rburst_d   = ARBURST;
        rbeat_d    = 8'd0;
        rcmd_err_d = bad_cmd(ARLEN, ARSIZE, ARBURST);
        raddr_d    = step(ARADDR, ARLEN, ARSIZE, ARBURST);
        rlast_d    = (ARLEN == 8'd0);
        r_state_d  = R_DATA;
      end
      R_DATA: if (RREADY && rvalid_q) begin
        if (rlast_q) begin
          rlast_d   = 1'b0;
          rresp_d   = 2'b00;
          r_state_d = R_IDLE;
        end else begin
          r_load  = 1'b1;
          rbeat_d = rbeat_q + 8'd1;
          raddr_d = step(raddr_q, rlen_q, rsize_q, rburst_q);
          rlast_d = (rbeat_q + 8'd1 == rlen_q);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load) begin
      rdata_d = (rcmd_err_d || !r_inr) ? '0 : mem[r_idx];
      rresp_d = (rcmd_err_d || !r_inr) ? 2'b10 : 2'b00;
    end
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q  <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
      rbeat_q    <= '0;
      rcmd_err_q <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rsize_q    <= rsize_d;
      rburst_q   <= rburst_d;
      rbeat_q    <= rbeat_d;
      rcmd_err_q <= rcmd_err_d;
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RLAST   = rlast_q;

endmodule
